// File: rtl/modbus_rtu_frame_rx_ctrl.sv
// Modbus RTU slave receive framer: splits the byte stream into frames by line silence,
// buffers each frame, checks its CRC-16 and address, and holds a good frame until acknowledged.
module modbus_rtu_frame_rx_ctrl #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic [7:0] dev_addr,
    input  logic       frame_ack,
    input  logic [7:0] frame_rd_addr,
    output logic [7:0] frame_rd_data,
    output logic [8:0] frame_len,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam longint BIT_CYC = longint'(CLK_FREQ / BAUD_RATE);
    // Above 19200 baud the silence limits are fixed times rather than character multiples.
    localparam longint T15_L = (BAUD_RATE <= 19200) ? (BIT_CYC * 33) / 2
                                                    : (longint'(CLK_FREQ) * 3) / 4000;
    localparam longint T35_L = (BAUD_RATE <= 19200) ? (BIT_CYC * 77) / 2
                                                    : (longint'(CLK_FREQ) * 7) / 4000;
    localparam logic [23:0] T15_CYC = 24'(T15_L);
    localparam logic [23:0] T35_CYC = 24'(T35_L);

    typedef enum logic [2:0] {
        S_IDLE_WAIT,
        S_IDLE,
        S_RECV,
        S_WAIT_EOF,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [8:0]  len_q, len_d;
    logic        bad_q, bad_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  sh_q, sh_d;
    logic [3:0]  bits_q, bits_d;
    logic [8:0]  frame_len_q, frame_len_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [7:0]  rd_q;

    logic        t15, t35;
    logic        crc_fb;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  mem [256];

    assign t15 = (cnt_q == T15_CYC);
    assign t35 = (cnt_q == T35_CYC);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE_WAIT;
            cnt_q       <= '0;
            len_q       <= '0;
            bad_q       <= 1'b0;
            addr_q      <= '0;
            crc_q       <= 16'hFFFF;
            sh_q        <= '0;
            bits_q      <= '0;
            frame_len_q <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            bad_q       <= bad_d;
            addr_q      <= addr_d;
            crc_q       <= crc_d;
            sh_q        <= sh_d;
            bits_q      <= bits_d;
            frame_len_q <= frame_len_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        bad_d       = bad_q;
        addr_d      = addr_q;
        crc_d       = crc_q;
        sh_d        = sh_q;
        bits_d      = bits_q;
        frame_len_d = frame_len_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = len_q[7:0];
        crc_fb      = crc_q[0] ^ sh_q[0];

        if (rx_done) begin
            cnt_d = '0;
        end else if (!t35) begin
            cnt_d = cnt_q + 24'd1;
        end

        // One CRC bit per cycle, LSB first, while a byte is pending.
        if (bits_q != 4'd0) begin
            crc_d  = {1'b0, crc_q[15:1]} ^ (crc_fb ? 16'hA001 : 16'h0000);
            sh_d   = {1'b0, sh_q[7:1]};
            bits_d = bits_q - 4'd1;
        end

        case (state_q)
            S_IDLE_WAIT: begin
                if (t35 && !rx_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (rx_done) begin
                    wr_en   = 1'b1;
                    wr_addr = 8'd0;
                    len_d   = 9'd1;
                    bad_d   = 1'b0;
                    addr_d  = rx_data;
                    crc_d   = 16'hFFFF;
                    sh_d    = rx_data;
                    bits_d  = 4'd8;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_done) begin
                    if (len_q < 9'd256) begin
                        wr_en = 1'b1;
                    end else begin
                        bad_d = 1'b1;
                    end
                    if (len_q != 9'h1FF) begin
                        len_d = len_q + 9'd1;
                    end
                    crc_d  = crc_q;
                    sh_d   = rx_data;
                    bits_d = 4'd8;
                end else if (t15) begin
                    state_d = S_WAIT_EOF;
                end
            end
            S_WAIT_EOF: begin
                if (rx_done) begin
                    bad_d = 1'b1;
                end else if (t35) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                frame_len_d = len_q;
                if (bad_q || (len_q < 9'd4) || (crc_q != 16'h0000)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if ((addr_q != dev_addr) && (addr_q != 8'h00)) begin
                    state_d = S_IDLE;
                end else begin
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Leaving HOLD mid-activity requires a fresh full silence before the next frame.
                if (frame_ack) begin
                    state_d = t35 ? S_IDLE : S_IDLE_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[frame_rd_addr];
        end
    end

    assign frame_rd_data = rd_q;
    assign frame_len     = frame_len_q;
    assign frame_valid   = valid_q;
    assign frame_err     = err_q;
    assign busy          = (state_q == S_RECV) || (state_q == S_WAIT_EOF) ||
                           (state_q == S_CHECK) || (state_q == S_HOLD);

endmodule

// File: tb/tb_modbus_rtu_frame_rx_ctrl.sv
// Bench for modbus_rtu_frame_rx_ctrl: frame-level reference model feeding a pulse/read scoreboard,
// directed cases plus randomized frames, with a scaled-down clock so silence limits stay short.
module tb_modbus_rtu_frame_rx_ctrl;
    localparam int CLK_FREQ  = 38400;
    localparam int BAUD_RATE = 9600;
    localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;
    localparam int T15       = BIT_CYC * 33 / 2;
    localparam int T35       = BIT_CYC * 77 / 2;
    localparam int CHAR      = 10 * BIT_CYC;
    localparam int SEP       = T35 + 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] dev_addr;
    logic       frame_ack;
    logic [7:0] frame_rd_addr;
    logic [7:0] frame_rd_data;
    logic [8:0] frame_len;
    logic       frame_valid;
    logic       frame_err;
    logic       busy;

    modbus_rtu_frame_rx_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .dev_addr     (dev_addr),
        .frame_ack    (frame_ack),
        .frame_rd_addr(frame_rd_addr),
        .frame_rd_data(frame_rd_data),
        .frame_len    (frame_len),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {bit is_err; int len; int due;} exp_t;
    typedef struct {logic [7:0] data; int at;} rd_t;
    exp_t sb_q[$];
    rd_t  rd_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: frames are reconstructed from byte spacing alone.
    logic [7:0] cur[$];
    logic [7:0] hold_bytes[$];
    bit         open_f, fbad, eof_seen, holding;
    int         f_last, last_strobe;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] crc16(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[i]) begin
            c = c ^ {8'h00, d[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic void close_frame();
        int n;
        bit is_err;
        if (!open_f) return;
        open_f = 1'b0;
        n      = cur.size();
        is_err = fbad || (n > 256) || (n < 4) || (crc16(cur) != 16'h0000);
        if (is_err) begin
            sb_q.push_back('{is_err: 1'b1, len: n, due: f_last + T35 + 2});
        end else if (cur[0] == dev_addr || cur[0] == 8'h00) begin
            sb_q.push_back('{is_err: 1'b0, len: n, due: f_last + T35 + 2});
            holding    = 1'b1;
            hold_bytes = cur;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int s, input int at);
        int idle;
        idle = s - 1;
        if (open_f && idle > T35) close_frame();
        if (holding) return;
        if (!open_f) begin
            if (idle > T35) begin
                open_f   = 1'b1;
                fbad     = 1'b0;
                eof_seen = 1'b0;
                cur.delete();
                cur.push_back(b);
                f_last   = at;
            end
        end else begin
            if (eof_seen || idle > T15) begin
                eof_seen = 1'b1;
                fbad     = 1'b1;
            end else begin
                cur.push_back(b);
            end
            f_last = at;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int s);
        int at;
        at = last_strobe + s;
        if (at < cyc + 1) at = cyc + 1;
        model_byte(b, at - last_strobe, at);
        while (cyc + 1 < at) begin
            @(posedge clk); #1;
        end
        rx_data     = b;
        rx_done     = 1'b1;
        last_strobe = at;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] q[$], input int first, input int gap,
                              input int gidx, input int glen);
        foreach (q[i]) begin
            send_byte(q[i], (i == 0) ? first : ((i == gidx) ? glen : gap));
        end
    endtask

    task automatic read_exp(input logic [7:0] a, input logic [7:0] e);
        frame_rd_addr = a;
        rd_q.push_back('{data: e, at: cyc + 1});
        @(posedge clk); #1;
    endtask

    task automatic settle();
        close_frame();
        repeat (T35 + 12) begin
            @(posedge clk); #1;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL pulse_missing: %0d expected pulses not seen, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic release_hold();
        if (holding) begin
            check("busy_in_hold", int'(busy), 1);
            foreach (hold_bytes[i]) read_exp(8'(i), hold_bytes[i]);
            frame_ack = 1'b1;
            @(posedge clk); #1;
            frame_ack = 1'b0;
            holding   = 1'b0;
            check("busy_after_ack", int'(busy), 0);
        end
    endtask

    task automatic monitor();
        exp_t e;
        rd_t  r;
        int   d;
        forever begin
            @(negedge clk);
            if (frame_valid || frame_err) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: valid=%0b err=%0b len=%0d at cycle %0d, required no pulse",
                             frame_valid, frame_err, frame_len, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_exclusive", int'(frame_valid & frame_err), 0);
                    check(e.is_err ? "err_pulse" : "valid_pulse",
                          int'(e.is_err ? frame_err : frame_valid), 1);
                    check("frame_len", int'(frame_len), e.len);
                    d = cyc - e.due;
                    total++;
                    if (d < -2 || d > 2) begin
                        bad++;
                        $display("FAIL pulse_time: got cycle %0d expected %0d +/-2", cyc, e.due);
                    end
                end
            end
            if (rd_q.size() != 0 && rd_q[0].at <= cyc) begin
                r = rd_q.pop_front();
                check("rd_data", int'(frame_rd_data), int'(r.data));
            end
        end
    endtask

    logic [7:0]  good[$], badf[$], bcast[$], other[$], fr[$];
    logic [15:0] c;
    int          sel, m, p, sp;

    initial begin
        fork
            monitor();
        join_none

        rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; dev_addr = 8'h01;
        frame_ack = 1'b0; frame_rd_addr = 8'h00;
        open_f = 1'b0; holding = 1'b0; fbad = 1'b0; eof_seen = 1'b0; f_last = 0;
        good  = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        bcast = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h85, 8'hDB};
        badf  = good;
        badf[7] = 8'h0B;
        other = '{8'h01, 8'h06, 8'h00, 8'h10, 8'h12, 8'h34, 8'h55, 8'hAA};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(frame_valid), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_len", int'(frame_len), 0);
        check("rst_rd_data", int'(frame_rd_data), 0);
        rst_n = 1'b1;
        last_strobe = cyc;

        // Good frame, with busy checked right after the first byte.
        send_byte(good[0], SEP);
        check("busy_first_byte", int'(busy), 1);
        for (int i = 1; i < 8; i++) send_byte(good[i], CHAR);
        settle(); release_hold();

        send_frame(badf, SEP, CHAR, -1, 0);  settle(); release_hold();

        dev_addr = 8'h02;
        send_frame(good, SEP, CHAR, -1, 0);  settle(); release_hold();
        dev_addr = 8'h01;
        send_frame(bcast, SEP, CHAR, -1, 0); settle(); release_hold();

        send_frame(good, SEP, CHAR, 3, 2 * CHAR); settle(); release_hold();
        send_frame(good, SEP, CHAR, 3, 4 * CHAR); settle(); release_hold();

        fr = '{8'h01, 8'h03, 8'h00};
        send_frame(fr, SEP, CHAR, -1, 0);    settle(); release_hold();

        fr.delete();
        for (int i = 0; i < 257; i++) fr.push_back(8'($urandom));
        send_frame(fr, SEP, CHAR, -1, 0);    settle();
        read_exp(8'd255, fr[255]);
        read_exp(8'd0, fr[0]);

        // A frame arriving in HOLD must leave the buffer alone and raise nothing.
        send_frame(good, SEP, CHAR, -1, 0);  settle();
        send_frame(other, SEP, CHAR, -1, 0); settle();
        release_hold();
        send_frame(good, SEP, CHAR, -1, 0);  settle(); release_hold();

        // Reset mid-frame, then a frame that arrives too soon, then a proper one.
        for (int i = 0; i < 3; i++) send_byte(good[i], (i == 0) ? SEP : CHAR);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", int'(busy), 0);
        check("midrst_len", int'(frame_len), 0);
        check("midrst_valid", int'(frame_valid), 0);
        check("midrst_err", int'(frame_err), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        open_f = 1'b0; holding = 1'b0;
        last_strobe = cyc;
        send_frame(good, CHAR, CHAR, -1, 0); settle(); release_hold();
        send_frame(good, SEP, CHAR, -1, 0);  settle(); release_hold();

        for (int k = 0; k < 12; k++) begin
            dev_addr = 8'($urandom_range(1, 247));
            sel = $urandom_range(0, 2);
            fr.delete();
            fr.push_back((sel == 0) ? dev_addr : ((sel == 1) ? 8'h00 : 8'(int'(dev_addr) % 247 + 1)));
            m = $urandom_range(0, 9);
            repeat (m) fr.push_back(8'($urandom));
            c = crc16(fr);
            fr.push_back(c[7:0]);
            fr.push_back(c[15:8]);
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, fr.size() - 1);
                fr[p] = fr[p] ^ 8'(1 << $urandom_range(0, 7));
            end
            sp = $urandom_range(CHAR, CHAR + 20);
            send_frame(fr, SEP + $urandom_range(0, 40), sp, -1, 0);
            settle();
            release_hold();
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        total++;
        if (rd_q.size() != 0) begin
            bad++;
            $display("FAIL rd_pending: %0d reads unchecked, required 0", rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modbus_rtu_frame_rx_ctrl.md
# modbus_rtu_frame_rx_ctrl

Frame-level receive controller for the Modbus RTU slave. It sits between the UART byte receiver and the request decoder. It consumes per-byte strobes and measures inter-character silence to delimit frames (T1.5 / T3.5). It stores bytes in an internal 256×8 buffer, checks the CRC-16 incrementally and filters on slave address. Each frame ends in one result pulse, and the buffer is held until the decoder acknowledges.

## Interface
- CLK_FREQ, 50000000, system clock in Hz
- BAUD_RATE, 9600, line rate
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rx_data  input  8  received byte, valid when rx_done=1
- rx_done  input  1  one-cycle strobe per received byte (spacing ≥ 1 character time)
- dev_addr  input  8  this slave's address (1–247)
- frame_ack  input  1  decoder releases buffer (one-cycle pulse)
- frame_rd_addr  input  8  buffer read index
- frame_rd_data  output  8  buffer byte, registered, 1-cycle read latency
- frame_len  output  9  byte count of last completed frame, CRC included
- frame_valid  output  1  one-cycle pulse: good frame for this slave or broadcast
- frame_err  output  1  one-cycle pulse: corrupt frame
- busy  output  1  high from first byte of a frame until return to IDLE/IDLE_WAIT

## Operation
- BIT_CYC = CLK_FREQ/BAUD_RATE, integer division. At 50 MHz / 9600 this is 5208.
- BAUD_RATE ≤ 19200:
  - T15_CYC = BIT_CYC*33/2, i.e. 16.5 bit times.
  - T35_CYC = BIT_CYC*77/2, i.e. 38.5 bit times.
  - At the defaults these are 85932 and 200508.
- BAUD_RATE > 19200: T15_CYC = CLK_FREQ*3/4000 (750 µs) and T35_CYC = CLK_FREQ*7/4000 (1.75 ms).
- Idle counter, 24 bits:
  - Cleared on rx_done.
  - Otherwise increments each cycle, saturating at T35_CYC.
  - Event t15 when the counter equals T15_CYC; event t35 when it equals T35_CYC.
- CRC engine:
  - Modbus CRC-16, reflected polynomial 0xA001, initialised to 0xFFFF at frame start.
  - Bit-serial: 8 cycles per byte, started by rx_done.
  - The frame passes when the residue over all bytes, CRC bytes included, is 0x0000.
- States:
  - IDLE_WAIT (reset state): ignore bytes and restart the idle counter on each one. On t35 → IDLE.
  - IDLE: on rx_done, write the byte at index 0, len=1, CRC init + update, bad=0 → RECV.
  - RECV: on rx_done, write at index len if len<256, otherwise set bad (overrun); then len+1 and CRC update. On t15 → WAIT_EOF.
  - WAIT_EOF: rx_done here sets bad (inter-character gap violation) and the byte is discarded; the state stays WAIT_EOF with the counter restarted. On t35 → CHECK.
  - CHECK (1 cycle): frame_len ← len. Exactly one of three outcomes:
    - Error → frame_err pulse, then IDLE. Error means bad, or len<4, or CRC residue ≠ 0.
    - Address mismatch → no pulse, then IDLE. Mismatch means buf[0] ∉ {dev_addr, 0x00}.
    - Otherwise → frame_valid pulse, then HOLD.
  - HOLD: buffer is write-protected and all rx_done are ignored; the idle counter keeps running. On frame_ack → IDLE if the counter equals T35_CYC, else IDLE_WAIT.
- frame_ack outside HOLD is ignored.
- Buffer reads are allowed in any state; contents are meaningful only in HOLD.
- frame_len holds its value until the next CHECK.

## Timing
- Reset values:
  - frame_valid=0, frame_err=0, busy=0.
  - frame_len=0, frame_rd_data=0.
  - State IDLE_WAIT, idle counter 0, CRC 0xFFFF.
- Reset mid-frame aborts the frame with no pulse. The controller then needs T35_CYC of silence before accepting a frame.
- frame_valid / frame_err assert T35_CYC+2 cycles after the cycle sampling the last rx_done. Bench tolerance is ±2 cycles. Each is high for exactly 1 cycle, and they are mutually exclusive.
- CRC completes 8 cycles after rx_done. rx_done spacing is far larger, so no overlap is possible.
- rx_done on the same cycle as t15 or t35: rx_done wins (counter cleared, byte taken in the current state).
- frame_rd_data = buf[frame_rd_addr] one cycle after the address is presented.

## Test plan
- **Good frame:** after reset, wait ≥T35, send back-to-back 01 03 00 00 00 01 84 0A with dev_addr=01.
  - One frame_valid pulse, frame_len=8, frame_err never high.
  - Reads of 0..7 return the bytes.
  - busy=1 from the first byte until frame_ack.
- **Bad CRC:** same frame with last byte 0B → frame_err pulse, frame_len=8, no frame_valid; controller returns to IDLE.
- **Address filter:** dev_addr=02 with the frame above → no pulse on either output. Broadcast 00 03 00 00 00 01 85 DB → frame_valid.
- **Gaps:**
  - A 2.0-character gap (between T1.5 and T3.5) after byte 3 of the good frame → one frame_err pulse after the final silence.
  - A 4-character gap → two separate frames, both frame_err (len<4, and CRC bad).
- **Length limits:**
  - Frame of 3 bytes → frame_err.
  - Frame of 257 bytes → frame_err, and buf[255] retains byte 256.
- **HOLD and reset:**
  - While in HOLD, send another frame → buffer unchanged and no pulse. Then frame_ack followed by T35 silence and a new good frame → frame_valid.
  - Assert rst_n_in mid-frame → all outputs return to 0 and the next frame is only accepted after T35 idle.
